fwd_hazard_ctrl: RTL and testbench

Forwarding and load-use hazard controller for the 5-stage pipeline. It keeps a shadow copy of destination and write-enable information for the ID/EX, EX/MEM and MEM/WB stages. From that copy it produces registered 2-bit select codes for the two EX-stage 3:1 ALU-operand muxes. It also raises a one-cycle stall with bubble insertion on load-use dependencies, sitting between ID decode and the EX operand muxes.

---
 rtl/pipe_ctrl_pkg.sv | 43 ++++
 rtl/fwd_shadow_reg.sv | 25 ++
 rtl/fwd_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: operand-mux select codes, hazard FSM states,
// shadow-stage record and the forwarding-priority helper.
package pipe_ctrl_pkg;

    localparam int PIPE_ADDR_W = 5;

    localparam logic [1:0] SEL_REGFILE = 2'd0;
    localparam logic [1:0] SEL_WB      = 2'd1;
    localparam logic [1:0] SEL_MEM     = 2'd2;

    typedef enum logic {
        ST_RUN,
        ST_STALLED
    } state_t;

    typedef struct packed {
        logic [PIPE_ADDR_W-1:0] Dest;
        logic                   RegWrite;
        logic                   MemRead;
    } shadow_t;

    // Youngest producer wins; register 0 is hardwired and never forwards.
    function automatic logic [1:0] fwd_select(
        input logic                   used,
        input logic [PIPE_ADDR_W-1:0] src,
        input logic [PIPE_ADDR_W-1:0] idex_dest,
        input logic                   idex_wr,
        input logic [PIPE_ADDR_W-1:0] exmem_dest,
        input logic                   exmem_wr
    );
        logic [1:0] sel;
        sel = SEL_REGFILE;
        if (used && (src != '0)) begin
            if (idex_wr && (idex_dest == src)) begin
                sel = SEL_MEM;
            end else if (exmem_wr && (exmem_dest == src)) begin
                sel = SEL_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/fwd_shadow_reg.sv
// One shadow pipeline stage holding destination/write-enable/load info.
// Cleared on reset and loaded with an all-zero NOP when a bubble is inserted.
module fwd_shadow_reg
    import pipe_ctrl_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_bubble,
    input  shadow_t i_d,
    output shadow_t o_q
);

    shadow_t r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_bubble) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller for the 5-stage pipeline.
// Selects are registered into EX; Stall/Bubble are combinational in ID.
module fwd_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int SEL_W      = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  IdValid,
    input  logic [REG_ADDR_W-1:0] IdRs,
    input  logic [REG_ADDR_W-1:0] IdRt,
    input  logic                  IdUsesRs,
    input  logic                  IdUsesRt,
    input  logic [REG_ADDR_W-1:0] IdDest,
    input  logic                  IdRegWrite,
    input  logic                  IdMemRead,
    input  logic                  Flush,
    output logic [SEL_W-1:0]      FwdSelA,
    output logic [SEL_W-1:0]      FwdSelB,
    output logic                  Stall,
    output logic                  Bubble
);

    shadow_t          w_id;
    shadow_t          w_idex;
    shadow_t          w_exmem;
    shadow_t          w_memwb;
    logic             w_kill;
    logic             w_hazard;
    logic             w_unused;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_sel_a;
    logic [SEL_W-1:0] r_sel_b;
    logic [SEL_W-1:0] w_sel_a;
    logic [SEL_W-1:0] w_sel_b;

    assign w_id.Dest     = IdDest;
    assign w_id.RegWrite = IdRegWrite;
    assign w_id.MemRead  = IdMemRead;

    // An invalid ID slot enters the shadow pipe as a NOP, same as a real bubble.
    assign w_kill = Bubble || !IdValid;

    fwd_shadow_reg u_idex (
        .i_clk    (Clk),
        .i_rst    (Reset),
        .i_bubble (w_kill),
        .i_d      (w_id),
        .o_q      (w_idex)
    );

    fwd_shadow_reg u_exmem (
        .i_clk    (Clk),
        .i_rst    (Reset),
        .i_bubble (1'b0),
        .i_d      (w_idex),
        .o_q      (w_exmem)
    );

    fwd_shadow_reg u_memwb (
        .i_clk    (Clk),
        .i_rst    (Reset),
        .i_bubble (1'b0),
        .i_d      (w_exmem),
        .o_q      (w_memwb)
    );

    // MEM/WB copy is kept for debug visibility only; WB data reaches ID via the regfile.
    assign w_unused = ^w_memwb;

    assign w_hazard = IdValid && w_idex.MemRead && w_idex.RegWrite && (w_idex.Dest != '0)
                   && ((IdUsesRs && (IdRs == w_idex.Dest)) || (IdUsesRt && (IdRt == w_idex.Dest)));

    always_comb begin
        w_state_nxt = ST_RUN;
        Stall       = 1'b0;
        Bubble      = 1'b0;
        if (Flush) begin
            Bubble = 1'b1;
        end else if ((r_state == ST_RUN) && w_hazard) begin
            Stall       = 1'b1;
            Bubble      = 1'b1;
            w_state_nxt = ST_STALLED;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_sel_a = fwd_select(IdUsesRs, IdRs, w_idex.Dest, w_idex.RegWrite,
                                w_exmem.Dest, w_exmem.RegWrite);
    assign w_sel_b = fwd_select(IdUsesRt, IdRt, w_idex.Dest, w_idex.RegWrite,
                                w_exmem.Dest, w_exmem.RegWrite);

    // ID -> EX boundary: selects follow the instruction into EX.
    always_ff @(posedge Clk) begin
        if (Reset || w_kill) begin
            r_sel_a <= SEL_REGFILE;
            r_sel_b <= SEL_REGFILE;
        end else begin
            r_sel_a <= w_sel_a;
            r_sel_b <= w_sel_b;
        end
    end

    assign FwdSelA = r_sel_a;
    assign FwdSelB = r_sel_b;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed pipeline scenarios plus randomized traffic,
// all checked every cycle against an instruction-history reference model.
module tb_fwd_hazard_ctrl;

    typedef struct {
        bit       v;
        bit [4:0] rs;
        bit [4:0] rt;
        bit       urs;
        bit       urt;
        bit [4:0] dst;
        bit       rw;
        bit       mr;
    } ins_t;

    logic       Clk;
    logic       Reset;
    logic       IdValid;
    logic [4:0] IdRs;
    logic [4:0] IdRt;
    logic       IdUsesRs;
    logic       IdUsesRt;
    logic [4:0] IdDest;
    logic       IdRegWrite;
    logic       IdMemRead;
    logic       Flush;
    logic [1:0] FwdSelA;
    logic [1:0] FwdSelB;
    logic       Stall;
    logic       Bubble;

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .SEL_W(2)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .IdValid    (IdValid),
        .IdRs       (IdRs),
        .IdRt       (IdRt),
        .IdUsesRs   (IdUsesRs),
        .IdUsesRt   (IdUsesRt),
        .IdDest     (IdDest),
        .IdRegWrite (IdRegWrite),
        .IdMemRead  (IdMemRead),
        .Flush      (Flush),
        .FwdSelA    (FwdSelA),
        .FwdSelB    (FwdSelB),
        .Stall      (Stall),
        .Bubble     (Bubble)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the two most recent instructions issued into EX
    // (hist[0] now in EX, hist[1] now in MEM), plus the expected EX selects.
    ins_t       hist [2];
    bit         m_stalled;
    logic [1:0] m_sel_a;
    logic [1:0] m_sel_b;

    logic [1:0] last_sel_a;
    logic [1:0] last_sel_b;
    logic       last_stall;
    logic       last_bub;

    function automatic ins_t nop_i();
        ins_t r;
        r = '{default: 0};
        r.v = 1'b1;
        return r;
    endfunction

    function automatic ins_t alu_i(input bit [4:0] d, input bit [4:0] s, input bit [4:0] t);
        ins_t r;
        r = '{v: 1'b1, rs: s, rt: t, urs: 1'b1, urt: 1'b1, dst: d, rw: 1'b1, mr: 1'b0};
        return r;
    endfunction

    function automatic ins_t lw_i(input bit [4:0] d, input bit [4:0] base);
        ins_t r;
        r = '{v: 1'b1, rs: base, rt: d, urs: 1'b1, urt: 1'b0, dst: d, rw: 1'b1, mr: 1'b1};
        return r;
    endfunction

    function automatic logic [1:0] m_fwd(input bit used, input bit [4:0] src);
        if (!used || src == 5'd0) return 2'd0;
        if (hist[0].rw && hist[0].dst == src) return 2'd2;
        if (hist[1].rw && hist[1].dst == src) return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_reset();
        hist[0]   = '{default: 0};
        hist[1]   = '{default: 0};
        m_stalled = 1'b0;
        m_sel_a   = 2'd0;
        m_sel_b   = 2'd0;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One pipeline cycle: drive ID, check all outputs at the falling edge, advance the model.
    task automatic cyc(input ins_t in, input bit fl, input bit rst);
        bit         haz;
        bit         e_stall;
        bit         e_bub;
        bit         kill;
        logic [1:0] na;
        logic [1:0] nb;
        IdValid    = in.v;
        IdRs       = in.rs;
        IdRt       = in.rt;
        IdUsesRs   = in.urs;
        IdUsesRt   = in.urt;
        IdDest     = in.dst;
        IdRegWrite = in.rw;
        IdMemRead  = in.mr;
        Flush      = fl;
        Reset      = rst;
        #4;
        haz = in.v && hist[0].mr && hist[0].rw && (hist[0].dst != 0)
              && ((in.urs && in.rs == hist[0].dst) || (in.urt && in.rt == hist[0].dst));
        e_stall = !m_stalled && haz && !fl;
        e_bub   = e_stall || fl;
        chk("stall",  {7'd0, Stall},  {7'd0, e_stall});
        chk("bubble", {7'd0, Bubble}, {7'd0, e_bub});
        chk("selA",   {6'd0, FwdSelA}, {6'd0, m_sel_a});
        chk("selB",   {6'd0, FwdSelB}, {6'd0, m_sel_b});
        last_sel_a = FwdSelA;
        last_sel_b = FwdSelB;
        last_stall = Stall;
        last_bub   = Bubble;
        @(posedge Clk);
        if (rst) begin
            model_reset();
        end else begin
            kill = e_bub || !in.v;
            na = kill ? 2'd0 : m_fwd(in.urs, in.rs);
            nb = kill ? 2'd0 : m_fwd(in.urt, in.rt);
            hist[1] = hist[0];
            if (kill) hist[0] = '{default: 0};
            else      hist[0] = in;
            m_sel_a   = na;
            m_sel_b   = nb;
            m_stalled = e_stall;
        end
        #1;
    endtask

    initial begin
        ins_t cur;
        bit   fl;
        bit   rs;
        IdValid = 0; IdRs = 0; IdRt = 0; IdUsesRs = 0; IdUsesRt = 0;
        IdDest = 0; IdRegWrite = 0; IdMemRead = 0; Flush = 0; Reset = 1;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_selA",   {6'd0, FwdSelA}, 8'd0);
        chk("rst_selB",   {6'd0, FwdSelB}, 8'd0);
        chk("rst_stall",  {7'd0, Stall},   8'd0);
        chk("rst_bubble", {7'd0, Bubble},  8'd0);
        model_reset();

        // add $3 <- $1,$2 ; sub $4 <- $3,$5
        cyc(alu_i(3, 1, 2), 0, 0);
        cyc(alu_i(4, 3, 5), 0, 0);
        chk("b2b_stall", {7'd0, last_stall}, 8'd0);
        cyc(nop_i(), 0, 0);
        chk("b2b_selA", {6'd0, last_sel_a}, 8'd2);
        chk("b2b_selB", {6'd0, last_sel_b}, 8'd0);

        // add $3 ; nop ; or $6 <- $3,$3
        cyc(alu_i(3, 1, 2), 0, 0);
        cyc(nop_i(), 0, 0);
        cyc(alu_i(6, 3, 3), 0, 0);
        cyc(nop_i(), 0, 0);
        chk("gap_selA", {6'd0, last_sel_a}, 8'd1);
        chk("gap_selB", {6'd0, last_sel_b}, 8'd1);

        // add $3 ; add $3 ; and $7 <- $3,$0
        cyc(alu_i(3, 1, 2), 0, 0);
        cyc(alu_i(3, 4, 5), 0, 0);
        cyc(alu_i(7, 3, 0), 0, 0);
        cyc(nop_i(), 0, 0);
        chk("dbl_selA", {6'd0, last_sel_a}, 8'd2);
        chk("dbl_selB", {6'd0, last_sel_b}, 8'd0);

        // lw $8,0($9) ; add $10 <- $8,$1 (stalls once, re-presented)
        cyc(lw_i(8, 9), 0, 0);
        cyc(alu_i(10, 8, 1), 0, 0);
        chk("lu_stall1", {7'd0, last_stall}, 8'd1);
        chk("lu_bub1",   {7'd0, last_bub},   8'd1);
        cyc(alu_i(10, 8, 1), 0, 0);
        chk("lu_stall2", {7'd0, last_stall}, 8'd0);
        chk("lu_bub2",   {7'd0, last_bub},   8'd0);
        cyc(nop_i(), 0, 0);
        chk("lu_selA", {6'd0, last_sel_a}, 8'd1);

        // rt matches the load but is not a source: no stall
        cur = alu_i(11, 1, 8);
        cur.urt = 1'b0;
        cyc(lw_i(8, 9), 0, 0);
        cyc(cur, 0, 0);
        chk("nors_stall", {7'd0, last_stall}, 8'd0);

        // Flush overrides the load-use hazard
        cyc(lw_i(8, 9), 0, 0);
        cyc(alu_i(10, 8, 1), 1, 0);
        chk("fl_stall", {7'd0, last_stall}, 8'd0);
        chk("fl_bub",   {7'd0, last_bub},   8'd1);
        cyc(nop_i(), 0, 0);
        chk("fl_selA", {6'd0, last_sel_a}, 8'd0);

        // back in RUN: a new load-use pair stalls; then reset while STALLED
        cyc(lw_i(8, 9), 0, 0);
        cyc(alu_i(10, 8, 1), 0, 0);
        chk("run_stall", {7'd0, last_stall}, 8'd1);
        cyc(alu_i(10, 8, 1), 0, 1);
        cyc(alu_i(10, 8, 1), 0, 0);
        chk("pr_stall",  {7'd0, last_stall}, 8'd0);
        chk("pr_bub",    {7'd0, last_bub},   8'd0);
        chk("pr_selA",   {6'd0, last_sel_a}, 8'd0);
        chk("pr_selB",   {6'd0, last_sel_b}, 8'd0);
        cyc(nop_i(), 0, 0);
        chk("pr_nofwd8", {6'd0, last_sel_a}, 8'd0);

        // back-to-back loads each stall independently
        cyc(lw_i(8, 9), 0, 0);
        cyc(lw_i(9, 8), 0, 0);
        chk("bbl_st1", {7'd0, last_stall}, 8'd1);
        cyc(lw_i(9, 8), 0, 0);
        cyc(alu_i(12, 9, 9), 0, 0);
        chk("bbl_st2", {7'd0, last_stall}, 8'd1);
        cyc(alu_i(12, 9, 9), 0, 0);

        // randomized traffic over a small register set; stalled ID is re-presented
        cur = nop_i();
        for (int i = 0; i < 600; i++) begin
            if (!last_stall) begin
                cur.v   = ($urandom_range(0, 99) < 88);
                cur.rs  = 5'($urandom_range(0, 6));
                cur.rt  = 5'($urandom_range(0, 6));
                cur.urs = ($urandom_range(0, 9) < 8);
                cur.urt = ($urandom_range(0, 9) < 6);
                cur.dst = 5'($urandom_range(0, 6));
                cur.rw  = ($urandom_range(0, 9) < 8);
                cur.mr  = ($urandom_range(0, 9) < 3);
            end
            fl = ($urandom_range(0, 99) < 8);
            rs = ($urandom_range(0, 99) < 2);
            cyc(cur, fl, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
